spi_slave: RTL and testbench

Receive end of the team's SPI link. Captures 16-bit words shifted out by the SPI master on `spi_cs_l` / `sclk` / `spi_data` (SPI mode 0, MSB first). Presents each completed word on a parallel output with a one-cycle valid strobe, and flags frames cut short by chip-select deassertion. Sits on the far side of the link from the master and runs on the system clock, oversampling the SPI lines.

---
 rtl/spi_slave.sv | 142 ++++++++++++++
 tb/tb_spi_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 receiver, MSB first, oversampled on the system clock.
// Delivers each complete WIDTH-bit word with a one-cycle valid strobe and
// reports frames aborted by chip-select deassertion with a one-cycle error strobe.
module spi_slave #(
  parameter int unsigned WIDTH = 16,
  parameter bit          SYNC  = 1'b1,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs_l,
  input  logic             sclk,
  input  logic             spi_data,
  output logic [WIDTH-1:0] dataout,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CW-1:0]    counter
);

  typedef enum logic [1:0] {
    WAIT_CS = 2'd0,
    IDLE    = 2'd1,
    SHIFT   = 2'd2
  } state_e;

  logic sclk_s, cs_s, data_s;
  logic sclk_q;
  logic rise;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     counter_q, counter_d;
  logic [WIDTH-1:0]  dataout_q, dataout_d;
  logic              data_valid_q, data_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;

  // Input path: matched-depth pipelines keep sclk, cs and data aligned.
  if (SYNC) begin : g_sync
    logic [1:0] sclk_sync_q, cs_sync_q, data_sync_q;

    // Two-flop synchronizers; chip select resets to its inactive level.
    always_ff @(posedge clk) begin
      if (reset) begin
        sclk_sync_q <= 2'b00;
        cs_sync_q   <= 2'b11;
        data_sync_q <= 2'b00;
      end else begin
        sclk_sync_q <= {sclk_sync_q[0], sclk};
        cs_sync_q   <= {cs_sync_q[0], spi_cs_l};
        data_sync_q <= {data_sync_q[0], spi_data};
      end
    end

    assign sclk_s = sclk_sync_q[1];
    assign cs_s   = cs_sync_q[1];
    assign data_s = data_sync_q[1];
  end else begin : g_nosync
    assign sclk_s = sclk;
    assign cs_s   = spi_cs_l;
    assign data_s = spi_data;
  end

  // Previous sclk sample for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) sclk_q <= 1'b0;
    else       sclk_q <= sclk_s;
  end

  assign rise = sclk_s & ~sclk_q;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_CS;
      shreg_q      <= '0;
      counter_q    <= '0;
      dataout_q    <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      counter_q    <= counter_d;
      dataout_q    <= dataout_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state: wait for cs idle, arm, then shift until full word or abort.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    counter_d    = counter_q;
    dataout_d    = dataout_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      WAIT_CS: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (!cs_s) begin
          shreg_d   = '0;
          counter_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The final bit wins over a simultaneous cs deassertion.
        if (rise && (counter_q == CW'(WIDTH - 1))) begin
          shreg_d      = {shreg_q[WIDTH-2:0], data_s};
          dataout_d    = {shreg_q[WIDTH-2:0], data_s};
          counter_d    = CW'(WIDTH);
          data_valid_d = 1'b1;
          state_d      = WAIT_CS;
        end else if (cs_s) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (rise) begin
          shreg_d   = {shreg_q[WIDTH-2:0], data_s};
          counter_d = counter_q + CW'(1);
        end
      end
      default: state_d = WAIT_CS;
    endcase

    busy_d = (state_d == SHIFT);
  end

  assign dataout    = dataout_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign counter    = counter_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives one SPI pin set into a SYNC=0 and a SYNC=1 receiver and
// checks both every cycle against a frame-level reference model.
module tb_spi_slave;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic reset, spi_cs_l, sclk, spi_data;

  logic [W-1:0]  dout0, dout1;
  logic          dv0, dv1, fe0, fe1, busy0, busy1;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run_chk = 1'b0;

  spi_slave #(.WIDTH(W), .SYNC(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .sclk(sclk), .spi_data(spi_data),
    .dataout(dout0), .data_valid(dv0), .frame_err(fe0), .busy(busy0), .counter(cnt0)
  );

  spi_slave #(.WIDTH(W), .SYNC(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .sclk(sclk), .spi_data(spi_data),
    .dataout(dout1), .data_valid(dv1), .frame_err(fe1), .busy(busy1), .counter(cnt1)
  );

  always #5 clk = ~clk;

  // Reference model, index 0 = no synchronizer, 1 = two-stage synchronizer.
  // mode 0: waiting to see cs idle, 1: armed, 2: receiving.
  int           m_mode [2];
  int           m_cnt  [2];
  int           m_val  [2];
  logic [W-1:0] m_dout [2];
  bit           m_dv   [2];
  bit           m_fe   [2];
  bit           m_prev [2];
  bit           d_cs [2], d_sc [2], d_d [2];
  bit           u_cs, u_sc, u_d, u_rise;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_val[i] = 0; m_dout[i] = '0;
      m_dv[i] = 1'b0; m_fe[i] = 1'b0; m_prev[i] = 1'b0;
      d_cs[i] = 1'b1; d_sc[i] = 1'b0; d_d[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        u_cs = spi_cs_l; u_sc = sclk; u_d = spi_data;
      end else begin
        u_cs = d_cs[1]; u_sc = d_sc[1]; u_d = d_d[1];
      end
      u_rise = u_sc && !m_prev[i];
      m_dv[i] = 1'b0;
      m_fe[i] = 1'b0;
      if (reset) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_val[i] = 0; m_dout[i] = '0; m_prev[i] = 1'b0;
      end else begin
        m_prev[i] = u_sc;
        if (m_mode[i] == 0) begin
          if (u_cs) m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
          if (!u_cs) begin m_mode[i] = 2; m_cnt[i] = 0; m_val[i] = 0; end
        end else begin
          if (u_rise && m_cnt[i] == W - 1) begin
            m_dout[i] = W'(m_val[i] * 2 + int'(u_d));
            m_cnt[i]  = W;
            m_dv[i]   = 1'b1;
            m_mode[i] = 0;
          end else if (u_cs) begin
            m_fe[i]   = 1'b1;
            m_mode[i] = 1;
          end else if (u_rise) begin
            m_val[i] = m_val[i] * 2 + int'(u_d);
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
    // Two-stage delay of the pins for the synchronized instance.
    if (reset) begin
      d_cs[0] = 1'b1; d_cs[1] = 1'b1;
      d_sc[0] = 1'b0; d_sc[1] = 1'b0;
      d_d[0]  = 1'b0; d_d[1]  = 1'b0;
    end else begin
      d_cs[1] = d_cs[0]; d_cs[0] = spi_cs_l;
      d_sc[1] = d_sc[0]; d_sc[0] = sclk;
      d_d[1]  = d_d[0];  d_d[0]  = spi_data;
    end
  end

  // Per-cycle compare plus pulse bookkeeping for the directed checks.
  int           n_dv [2];
  int           n_fe [2];
  int           dv_cyc [2];
  logic [W-1:0] dvq1 [$];
  logic [23:0]  got_v, exp_v;

  initial begin
    for (int i = 0; i < 2; i++) begin n_dv[i] = 0; n_fe[i] = 0; dv_cyc[i] = 0; end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      got_v = {dout0, dv0, fe0, busy0, cnt0};
      exp_v = {m_dout[0], m_dv[0], m_fe[0], m_mode[0] == 2, CW'(m_cnt[0])};
      checks = checks + 1;
      if (got_v !== exp_v) begin
        errors = errors + 1;
        $display("FAIL outs_sync0 cyc=%0d got %h exp %h (dout,dv,fe,busy,cnt)", cyc, got_v, exp_v);
      end
      got_v = {dout1, dv1, fe1, busy1, cnt1};
      exp_v = {m_dout[1], m_dv[1], m_fe[1], m_mode[1] == 2, CW'(m_cnt[1])};
      checks = checks + 1;
      if (got_v !== exp_v) begin
        errors = errors + 1;
        $display("FAIL outs_sync1 cyc=%0d got %h exp %h (dout,dv,fe,busy,cnt)", cyc, got_v, exp_v);
      end
    end
    if (dv0 === 1'b1) begin n_dv[0] = n_dv[0] + 1; dv_cyc[0] = cyc; end
    if (dv1 === 1'b1) begin n_dv[1] = n_dv[1] + 1; dv_cyc[1] = cyc; dvq1.push_back(dout1); end
    if (fe0 === 1'b1) n_fe[0] = n_fe[0] + 1;
    if (fe1 === 1'b1) n_fe[1] = n_fe[1] + 1;
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int rise_cyc = 0;

  // Shift out nb bits MSB first; half = clk cycles per sclk phase.
  // drop_last raises cs together with the final rising edge.
  task automatic send(input logic [W-1:0] w, input int nb, input int half, input bit drop_last);
    for (int b = 0; b < nb; b++) begin
      spi_data = (b < W) ? w[W-1-b] : 1'($urandom_range(0, 1));
      sclk = 1'b0;
      tick(half);
      sclk = 1'b1;
      if (drop_last && b == nb - 1) spi_cs_l = 1'b1;
      rise_cyc = cyc;
      tick(half);
    end
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [W-1:0] w, input int nb, input int half, input int gap);
    spi_cs_l = 1'b0;
    tick(1);
    send(w, nb, half, 1'b0);
    tick(1);
    spi_cs_l = 1'b1;
    tick(gap);
  endtask

  int b_dv0, b_dv1, b_fe0, b_fe1;

  task automatic snap();
    b_dv0 = n_dv[0]; b_dv1 = n_dv[1]; b_fe0 = n_fe[0]; b_fe1 = n_fe[1];
  endtask

  initial begin
    logic [W-1:0] w;
    int nb, half, mode;
    reset = 1'b1; spi_cs_l = 1'b1; sclk = 1'b0; spi_data = 1'b0;
    tick(1);
    run_chk = 1'b1;
    tick(2);
    chk("reset_dout1", int'(dout1), 0);
    chk("reset_cnt_busy1", int'({busy1, cnt1}), 0);
    reset = 1'b0;
    tick(3);

    // Single frame, 4-clk sclk period.
    snap();
    frame(16'hA569, 16, 2, 6);
    chk("single_dout1", int'(dout1), 16'hA569);
    chk("single_dv1_pulses", n_dv[1] - b_dv1, 1);
    chk("single_cnt1", int'(cnt1), 16);

    // Back-to-back with a 2-cycle cs-high gap.
    snap();
    dvq1.delete();
    frame(16'h1234, 16, 3, 2);
    frame(16'hFFFF, 16, 3, 6);
    chk("b2b_dv1_pulses", n_dv[1] - b_dv1, 2);
    chk("b2b_first_word", (dvq1.size() > 0) ? int'(dvq1[0]) : -1, 16'h1234);
    chk("b2b_second_word", (dvq1.size() > 1) ? int'(dvq1[1]) : -1, 16'hFFFF);
    chk("b2b_no_fe", (n_fe[0] - b_fe0) + (n_fe[1] - b_fe1), 0);

    // Abort after 7 bits.
    snap();
    frame(16'h5A5A, 7, 3, 6);
    chk("abort_fe0", n_fe[0] - b_fe0, 1);
    chk("abort_fe1", n_fe[1] - b_fe1, 1);
    chk("abort_cnt1", int'(cnt1), 7);
    chk("abort_dout_kept", int'(dout1), 16'hFFFF);
    chk("abort_no_dv", n_dv[1] - b_dv1, 0);

    // Three extra sclk pulses after a full word.
    snap();
    frame(16'h0F0F, 19, 3, 6);
    chk("extra_dv1_pulses", n_dv[1] - b_dv1, 1);
    chk("extra_dout1", int'(dout1), 16'h0F0F);
    chk("extra_cnt1", int'(cnt1), 16);

    // Chip select rising with the final edge: 16th bit completes, 5th does not.
    snap();
    spi_cs_l = 1'b0; tick(1); send(16'h6B2D, 16, 3, 1'b1); tick(8);
    chk("cs_edge16_dv0", n_dv[0] - b_dv0, 1);
    chk("cs_edge16_dout0", int'(dout0), 16'h6B2D);
    chk("cs_edge16_no_fe0", n_fe[0] - b_fe0, 0);
    snap();
    spi_cs_l = 1'b0; tick(1); send(16'hFFFF, 5, 3, 1'b1); tick(8);
    chk("cs_edge5_fe0", n_fe[0] - b_fe0, 1);
    chk("cs_edge5_cnt0", int'(cnt0), 4);

    // Reset in the middle of a frame; the master completes it regardless.
    // The synchronized instance sees its cs pipeline reset high, so only the
    // unsynchronized one is pinned to silence here; the model covers both.
    snap();
    spi_cs_l = 1'b0; tick(1);
    send(16'hBEEF, 8, 3, 1'b0);
    reset = 1'b1; tick(1); reset = 1'b0;
    send(16'hEF00, 8, 3, 1'b0);
    tick(1); spi_cs_l = 1'b1; tick(6);
    chk("midreset_no_dv0", n_dv[0] - b_dv0, 0);
    chk("midreset_no_fe0", n_fe[0] - b_fe0, 0);
    chk("midreset_no_dv1", n_dv[1] - b_dv1, 0);
    frame(16'hC3C3, 16, 3, 6);
    chk("after_reset_dout0", int'(dout0), 16'hC3C3);
    chk("after_reset_dout1", int'(dout1), 16'hC3C3);

    // 2-clk sclk period; latency counted from the clock edge launching the 16th rise.
    spi_cs_l = 1'b0; tick(1);
    send(16'h8001, 16, 1, 1'b0);
    tick(6); spi_cs_l = 1'b1; tick(4);
    chk("fast_dout0", int'(dout0), 16'h8001);
    chk("fast_latency0", dv_cyc[0] - rise_cyc + 1, 2);
    chk("fast_latency1", dv_cyc[1] - rise_cyc + 1, 4);

    // Random frames: lengths below, at and above WIDTH, mixed rates, stray resets.
    for (int k = 0; k < 60; k++) begin
      w    = W'($urandom);
      nb   = $urandom_range(0, 19);
      half = $urandom_range(1, 4);
      mode = $urandom_range(0, 7);
      spi_cs_l = 1'b0;
      tick($urandom_range(1, 3));
      if (mode == 0 && nb > 2) begin
        send(w, nb / 2, half, 1'b0);
        reset = 1'b1; tick(1); reset = 1'b0;
        send(W'(w << (nb / 2)), nb - nb / 2, half, 1'b0);
      end else begin
        send(w, nb, half, mode == 1);
      end
      tick($urandom_range(0, 2));
      spi_cs_l = 1'b1;
      tick($urandom_range(1, 5));
    end
    tick(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
